// File: rtl/pool_flatten_engine.sv
// pool_flatten_engine
// 2x2 stride-2 max-pooling back end. Reads both layer-0 maps over the shared
// memory bus and writes each pooled value to its layer-1 memory and, interleaved
// by kernel, to the layer-2 flatten memory. For each pooled index (ascending) it
// processes kernel 0, then kernel 1. Each window takes 7 cycles.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-low reset
//   start     one-cycle request to process both layer-0 maps
//   busy      high while processing
//   done      one-cycle completion pulse
//   crd       memory read enable
//   caddr_rd  read address
//   cdata_rd  read data, valid the cycle after crd/caddr_rd/csel are presented
//   cwr       memory write enable
//   caddr_wr  write address
//   cdata_wr  write data
//   csel      memory select: 001 L0k0, 010 L0k1, 011 L1k0, 100 L1k1, 101 L2
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start
// S_RD    | 4 read cycles over the 2x2 window, folding the previous read
// S_CAP   | fold the 4th read value
// S_WR_L1 | write the max to the layer-1 memory of the current kernel
// S_WR_L2 | write the max to the flatten memory at 2*i + k
// S_DONE  | one-cycle done pulse
module pool_flatten_engine #(
   parameter int DATA_W = 20,
   parameter int IMG_W  = 64,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              crd,
   output logic [ADDR_W-1:0] caddr_rd,
   input  logic [DATA_W-1:0] cdata_rd,
   output logic              cwr,
   output logic [ADDR_W-1:0] caddr_wr,
   output logic [DATA_W-1:0] cdata_wr,
   output logic [2:0]        csel
);

   localparam int LOG_W = $clog2(IMG_W);
   localparam int HALF  = LOG_W - 1;
   localparam int IDX_W = 2 * HALF;
   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_CAP   = 3'd2,
      S_WR_L1 = 3'd3,
      S_WR_L2 = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [1:0]        r_rd_cnt, w_rd_cnt_nx;
   logic [IDX_W-1:0]  r_idx, w_idx_nx;
   logic              r_kern, w_kern_nx;
   logic [DATA_W-1:0] r_max;
   logic [DATA_W-1:0] w_fold;

   logic              w_busy_nx, w_done_nx, w_crd_nx, w_cwr_nx;
   logic [2:0]        w_csel_nx;
   logic [ADDR_W-1:0] w_caddr_rd_nx, w_caddr_wr_nx;
   logic [DATA_W-1:0] w_cdata_wr_nx;
   logic [2*LOG_W-1:0] w_rd_addr;

   // Unsigned replace-if-greater; ties keep the current value.
   assign w_fold = (cdata_rd > r_max) ? cdata_rd : r_max;

   // Window address {r, dy, c, dx} == (2r+dy)*IMG_W + 2c+dx.
   assign w_rd_addr = {w_idx_nx[IDX_W-1:HALF], w_rd_cnt_nx[1],
                       w_idx_nx[HALF-1:0], w_rd_cnt_nx[0]};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_rd_cnt <= '0;
         r_idx    <= '0;
         r_kern   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_rd_cnt <= w_rd_cnt_nx;
         r_idx    <= w_idx_nx;
         r_kern   <= w_kern_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_rd_cnt_nx = r_rd_cnt;
      w_idx_nx    = r_idx;
      w_kern_nx   = r_kern;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nx  = S_RD;
               w_rd_cnt_nx = '0;
               w_idx_nx    = '0;
               w_kern_nx   = 1'b0;
            end
         end
         S_RD: begin
            if (r_rd_cnt == 2'd3) w_state_nx = S_CAP;
            else                  w_rd_cnt_nx = r_rd_cnt + 2'd1;
         end
         S_CAP:   w_state_nx = S_WR_L1;
         S_WR_L1: w_state_nx = S_WR_L2;
         S_WR_L2: begin
            w_rd_cnt_nx = '0;
            if (r_kern && (r_idx == IDX_LAST)) begin
               w_state_nx = S_DONE;
               w_idx_nx   = '0;
               w_kern_nx  = 1'b0;
            end else begin
               w_state_nx = S_RD;
               w_kern_nx  = ~r_kern;
               if (r_kern) w_idx_nx = r_idx + 1'b1;
            end
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from the next state so that
   // every bus output comes straight from a flop.
   always_comb begin
      w_busy_nx     = 1'b0;
      w_done_nx     = 1'b0;
      w_crd_nx      = 1'b0;
      w_cwr_nx      = 1'b0;
      w_csel_nx     = 3'b000;
      w_caddr_rd_nx = caddr_rd;
      w_caddr_wr_nx = caddr_wr;
      w_cdata_wr_nx = (r_state == S_CAP) ? w_fold : cdata_wr;
      case (w_state_nx)
         S_RD: begin
            w_busy_nx     = 1'b1;
            w_crd_nx      = 1'b1;
            w_csel_nx     = w_kern_nx ? 3'b010 : 3'b001;
            w_caddr_rd_nx = ADDR_W'(w_rd_addr);
         end
         S_CAP: w_busy_nx = 1'b1;
         S_WR_L1: begin
            w_busy_nx     = 1'b1;
            w_cwr_nx      = 1'b1;
            w_csel_nx     = w_kern_nx ? 3'b100 : 3'b011;
            w_caddr_wr_nx = ADDR_W'(w_idx_nx);
         end
         S_WR_L2: begin
            w_busy_nx     = 1'b1;
            w_cwr_nx      = 1'b1;
            w_csel_nx     = 3'b101;
            w_caddr_wr_nx = ADDR_W'({w_idx_nx, w_kern_nx});
         end
         S_DONE:  w_done_nx = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         crd      <= 1'b0;
         cwr      <= 1'b0;
         csel     <= 3'b000;
         caddr_rd <= '0;
         caddr_wr <= '0;
         cdata_wr <= '0;
      end else begin
         busy     <= w_busy_nx;
         done     <= w_done_nx;
         crd      <= w_crd_nx;
         cwr      <= w_cwr_nx;
         csel     <= w_csel_nx;
         caddr_rd <= w_caddr_rd_nx;
         caddr_wr <= w_caddr_wr_nx;
         cdata_wr <= w_cdata_wr_nx;
      end
   end

   // First read cycle of a window clears the running max; its read data
   // belongs to the previous window and is ignored.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_max <= '0;
      end else begin
         case (r_state)
            S_RD:    r_max <= (r_rd_cnt == 2'd0) ? '0 : w_fold;
            S_CAP:   r_max <= w_fold;
            default: r_max <= r_max;
         endcase
      end
   end

endmodule

// File: tb/tb_pool_flatten_engine.sv
module tb_pool_flatten_engine;

   localparam int FRAME_BUSY = 14336;
   localparam logic [19:0] SENT = 20'hBAD01;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, crd, cwr;
   logic [11:0] caddr_rd, caddr_wr;
   logic [19:0] cdata_rd, cdata_wr;
   logic [2:0]  csel;

   pool_flatten_engine #(.DATA_W(20), .IMG_W(64), .ADDR_W(12)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
      .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
   );

   always #5 clk = ~clk;

   logic [19:0] mem [0:7][0:4095];
   int          cyc = 0;
   int          first_crd = -1;
   int          busy_cnt, done_cnt, ovl_cnt;
   logic [2:0]  log_sel [$];
   int          log_addr [$];
   int          log_cyc [$];
   int          checks = 0;
   int          errors = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (crd) cdata_rd <= mem[csel][caddr_rd];
      if (cwr) begin
         mem[csel][caddr_wr] <= cdata_wr;
         log_sel.push_back(csel);
         log_addr.push_back(int'(caddr_wr));
         log_cyc.push_back(cyc);
      end
      if (crd && first_crd < 0) first_crd = cyc;
   end

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (crd === 1'b1 && cwr === 1'b1) ovl_cnt++;
   end

   // Golden pooled value straight from the layer-0 map contents.
   function automatic logic [19:0] gold(int k, int i);
      int r, c, base;
      logic [19:0] m, v;
      r = i / 32;
      c = i % 32;
      base = 2 * r * 64 + 2 * c;
      m = 0;
      for (int d = 0; d < 4; d++) begin
         v = mem[1 + k][base + (d / 2) * 64 + (d % 2)];
         if (v > m) m = v;
      end
      return m;
   endfunction

   task automatic clear_outputs();
      for (int a = 0; a < 1024; a++) begin
         mem[3][a] = SENT;
         mem[4][a] = SENT;
      end
      for (int a = 0; a < 2048; a++) mem[5][a] = SENT;
      log_sel.delete();
      log_addr.delete();
      log_cyc.delete();
      first_crd = -1;
      busy_cnt = 0;
      done_cnt = 0;
      ovl_cnt = 0;
   endtask

   task automatic fill_random();
      for (int a = 0; a < 4096; a++) begin
         if ($urandom_range(0, 3) == 0) begin
            mem[1][a] = 20'($urandom_range(0, 7));
            mem[2][a] = 20'($urandom_range(0, 7));
         end else begin
            mem[1][a] = 20'($urandom);
            mem[2][a] = 20'($urandom);
         end
      end
   endtask

   task automatic run_frame(input bit poke);
      bit fin;
      fin = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int n = 0; n < 20000; n++) begin
         @(negedge clk);
         start = (poke && (n == 100 || n == 7000 || n == 14000)) ? 1'b1 : 1'b0;
         if (done === 1'b1) begin
            fin = 1;
            break;
         end
      end
      start = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL frame_timeout: done not seen within 20000 cycles (required within 20000)");
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_frame(input string name);
      int bad, prints, i, k;
      logic [19:0] exp;
      checks++;
      if (busy_cnt != FRAME_BUSY) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, FRAME_BUSY);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL %s done_pulse_cycles: got %0d required 1", name, done_cnt);
      end
      checks++;
      if (ovl_cnt != 0) begin
         errors++;
         $display("FAIL %s crd_cwr_overlap: got %0d required 0", name, ovl_cnt);
      end
      checks++;
      if (log_sel.size() != 4096) begin
         errors++;
         $display("FAIL %s write_count: got %0d required 4096", name, log_sel.size());
      end
      bad = 0;
      for (int j = 0; j < 2048 && 2 * j + 1 < log_sel.size(); j++) begin
         i = j / 2;
         k = j % 2;
         if (log_sel[2*j] !== 3'(3 + k) || log_addr[2*j] != i ||
             log_sel[2*j+1] !== 3'd5 || log_addr[2*j+1] != 2 * i + k) begin
            if (bad == 0)
               $display("FAIL %s write_order at window %0d k %0d: got sel %0d/%0d addr %0d/%0d required sel %0d/5 addr %0d/%0d",
                        name, i, k, log_sel[2*j], log_sel[2*j+1], log_addr[2*j], log_addr[2*j+1], 3 + k, i, 2 * i + k);
            bad++;
         end
      end
      checks++;
      if (bad != 0) errors++;
      prints = 0;
      for (int kk = 0; kk < 2; kk++) begin
         for (int ii = 0; ii < 1024; ii++) begin
            exp = gold(kk, ii);
            checks++;
            if (mem[3 + kk][ii] !== exp) begin
               errors++;
               if (prints++ < 10)
                  $display("FAIL %s l1_k%0d[%0d]: got %h required %h", name, kk, ii, mem[3 + kk][ii], exp);
            end
            checks++;
            if (mem[5][2 * ii + kk] !== exp) begin
               errors++;
               if (prints++ < 10)
                  $display("FAIL %s l2[%0d]: got %h required %h", name, 2 * ii + kk, mem[5][2 * ii + kk], exp);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         start = ~start;
         checks++;
         if ({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy %b done %b crd %b cwr %b csel %b ard %h awr %h dwr %h required all zero",
                     busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr);
         end
      end
      @(negedge clk);
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || crd !== 1'b0 || cwr !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: got busy %b crd %b cwr %b required 0 0 0", busy, crd, cwr);
      end
   endtask

   task automatic test_single_bounds();
      for (int a = 0; a < 4096; a++) begin
         mem[1][a] = '0;
         mem[2][a] = '0;
      end
      mem[1][0] = 20'd5;  mem[1][1] = 20'd9;  mem[1][64] = 20'd3;  mem[1][65] = 20'd7;
      mem[1][10] = 20'h00ABC; mem[1][11] = 20'h00ABC; mem[1][74] = 20'h00ABC; mem[1][75] = 20'h00ABC;
      mem[2][4095] = 20'hFFFFF; mem[2][4094] = 20'h00001; mem[2][4031] = 20'h00001; mem[2][4030] = 20'h00001;
      clear_outputs();
      run_frame(0);
      checks++;
      if (log_sel.size() < 2 || log_sel[0] !== 3'b011 || log_addr[0] != 0 || log_cyc[0] - first_crd != 5) begin
         errors++;
         $display("FAIL single_wr_l1: got sel %b addr %0d delay %0d required 011 0 5",
                  log_sel.size() > 0 ? log_sel[0] : 3'bxxx, log_addr.size() > 0 ? log_addr[0] : -1,
                  log_cyc.size() > 0 ? log_cyc[0] - first_crd : -1);
      end
      checks++;
      if (log_sel.size() < 2 || log_sel[1] !== 3'b101 || log_addr[1] != 0 || log_cyc[1] - first_crd != 6) begin
         errors++;
         $display("FAIL single_wr_l2: got sel %b addr %0d delay %0d required 101 0 6",
                  log_sel.size() > 1 ? log_sel[1] : 3'bxxx, log_addr.size() > 1 ? log_addr[1] : -1,
                  log_cyc.size() > 1 ? log_cyc[1] - first_crd : -1);
      end
      checks++;
      if (mem[3][0] !== 20'd9 || mem[5][0] !== 20'd9) begin
         errors++;
         $display("FAIL single_data: got l1 %h l2 %h required 00009 00009", mem[3][0], mem[5][0]);
      end
      checks++;
      if (mem[4][1023] !== 20'hFFFFF || mem[5][2047] !== 20'hFFFFF) begin
         errors++;
         $display("FAIL bound_max: got l1k1 %h l2 %h required fffff fffff", mem[4][1023], mem[5][2047]);
      end
      checks++;
      if (mem[3][2] !== 20'h0 || mem[4][0] !== 20'h0) begin
         errors++;
         $display("FAIL zero_window: got %h %h required 00000 00000", mem[3][2], mem[4][0]);
      end
      checks++;
      if (mem[3][5] !== 20'h00ABC || mem[5][10] !== 20'h00ABC) begin
         errors++;
         $display("FAIL equal_window: got %h %h required 00abc 00abc", mem[3][5], mem[5][10]);
      end
      check_frame("single_bounds");
   endtask

   task automatic test_random_frame();
      fill_random();
      clear_outputs();
      run_frame(0);
      check_frame("random_frame");
   endtask

   task automatic test_midrun_reset_restart();
      int nw;
      fill_random();
      clear_outputs();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (5000) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checks++;
      if (busy !== 1'b0 || cwr !== 1'b0 || crd !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: got busy %b cwr %b crd %b required 0 0 0", busy, cwr, crd);
      end
      nw = log_sel.size();
      repeat (50) @(negedge clk);
      checks++;
      if (log_sel.size() != nw || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_quiet: got writes %0d busy %b required writes %0d busy 0", log_sel.size(), busy, nw);
      end
      clear_outputs();
      run_frame(1);
      check_frame("restart_with_start_pokes");
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      for (int s = 0; s < 8; s++)
         for (int a = 0; a < 4096; a++) mem[s][a] = '0;
      test_reset();
      test_single_bounds();
      test_random_frame();
      test_midrun_reset_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
